// File: rtl/seq_detect_ctrl.sv
// seq_detect_ctrl: accepts bytes over valid/ready, serialises them MSB-first
// one bit per clock, and matches the bit stream against a runtime-programmed
// pattern of 1..PAT_MAX bits (overlapping or non-overlapping). Matches are
// registered one-cycle pulses and are tallied in a saturating counter.
module seq_detect_ctrl #(
    parameter int PAT_MAX = 8,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_we,
    input  logic [PAT_MAX-1:0] cfg_pattern,
    input  logic [3:0]         cfg_len,
    input  logic               cfg_overlap,
    output logic               cfg_err,
    input  logic               cnt_clr,
    input  logic               in_valid,
    input  logic [7:0]         in_data,
    output logic               in_ready,
    output logic               match,
    output logic [CNT_W-1:0]   match_count,
    output logic               busy
);

    localparam int FW = $clog2(PAT_MAX + 1);

    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    state_t             state, next_state;
    logic [2:0]         bit_idx;
    logic [7:0]         byte_reg;
    logic [PAT_MAX-1:0] hist;
    logic [FW-1:0]      fill;
    logic [PAT_MAX-1:0] pattern;
    logic [3:0]         len;
    logic               overlap;

    logic               handshake;
    logic               cfg_ok;
    logic               cur_bit;
    logic [PAT_MAX-1:0] new_hist;
    logic [FW-1:0]      new_fill;
    logic [PAT_MAX-1:0] len_mask;
    logic               hit;

    assign handshake = in_valid && in_ready;

    // A config write is taken only between bytes and only with a legal length,
    // so the active config never changes under a byte being serialised.
    assign cfg_ok = cfg_we && (state == IDLE) && (cfg_len != 4'd0)
                    && (int'(cfg_len) <= PAT_MAX);

    // Current bit and the history/fill as they will look after this bit.
    always_comb begin
        cur_bit  = byte_reg[3'd7 - bit_idx];
        new_hist = {hist[PAT_MAX-2:0], cur_bit};
        new_fill = (int'(fill) >= PAT_MAX) ? fill : fill + 1'b1;
        len_mask = '0;
        for (int i = 0; i < PAT_MAX; i++)
            len_mask[i] = (i < int'(len));
        // Match is judged on the updated history; fill guards against
        // matching on bits that were cleared rather than received.
        hit = (state == SHIFT)
              && (((new_hist ^ pattern) & len_mask) == '0)
              && (int'(new_fill) >= int'(len));
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // FSM next-state: reload on the last bit if a new byte is offered
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (handshake) next_state = SHIFT;
            SHIFT:   if (bit_idx == 3'd7 && !handshake) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // FSM outputs: ready while idle or on the last bit, for gapless streaming
    always_comb begin
        in_ready = (state == IDLE) || (state == SHIFT && bit_idx == 3'd7);
        busy     = (state == SHIFT);
    end

    // Datapath: byte holding, bit index, history, config and match tally
    always_ff @(posedge clk) begin
        if (reset) begin
            bit_idx     <= '0;
            byte_reg    <= '0;
            hist        <= '0;
            fill        <= '0;
            pattern     <= '0;
            len         <= 4'd1;
            overlap     <= 1'b0;
            match       <= 1'b0;
            match_count <= '0;
            cfg_err     <= 1'b0;
        end else begin
            if (handshake) begin
                byte_reg <= in_data;
                bit_idx  <= '0;
            end else if (state == SHIFT) begin
                bit_idx  <= bit_idx + 3'd1;
            end

            // cfg_ok implies IDLE, so it never races with a shift
            if (cfg_ok) begin
                pattern <= cfg_pattern;
                len     <= cfg_len;
                overlap <= cfg_overlap;
                hist    <= '0;
                fill    <= '0;
            end else if (state == SHIFT) begin
                hist <= new_hist;
                fill <= (hit && !overlap) ? '0 : new_fill;
            end

            match <= hit;

            // A rejected write in the same cycle as a clear leaves the flag set
            if (cfg_we && !cfg_ok) cfg_err <= 1'b1;
            else if (cnt_clr)      cfg_err <= 1'b0;

            // Clear takes effect before the coincident match is counted
            if (cnt_clr)
                match_count <= hit ? CNT_W'(1) : '0;
            else if (hit && match_count != {CNT_W{1'b1}})
                match_count <= match_count + 1'b1;
        end
    end

endmodule
